// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: req/ack fetch FSM, multi-word fetch and a decoupling queue to ID.
// Optional performance counters are enabled with macro IF_PERF_CNT_EN.
module if_fetch_queue #(
  parameter int unsigned FETCH_W    = 2,
  parameter int unsigned IBUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'hbfc0_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 branch_valid,
  input  logic [31:0]          branch_pc,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [32*FETCH_W-1:0] imem_rdata,
  input  logic                 imem_err,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_inst,
  output logic [31:0]          id_pc,
  output logic [1:0]           id_exc,
  output logic [31:0]          pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] BLK_BYTES  = 32'(4 * FETCH_W);
  localparam logic [31:0] ALIGN_MASK = ~(BLK_BYTES - 32'd1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);
  localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_W);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             halt_q, halt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      inst_q [IBUF_DEPTH];
  logic [31:0]      inst_d [IBUF_DEPTH];
  logic [31:0]      qpc_q  [IBUF_DEPTH];
  logic [31:0]      qpc_d  [IBUF_DEPTH];
  logic [1:0]       exc_q  [IBUF_DEPTH];
  logic [1:0]       exc_d  [IBUF_DEPTH];

  logic [CNT_W-1:0] free_slots;
  logic             misalign;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             fetch_ok;
  logic             ack_take;
  logic             pop;
  int unsigned      start_slot;

  assign free_slots = DEPTH_C - count_q;
  assign misalign   = pc_q[1:0] != 2'b00;
  assign flush      = redirect_valid | branch_valid;
  assign flush_pc   = redirect_valid ? redirect_pc : branch_pc;
  assign fetch_ok   = (state_q == ST_FETCH) && !halt_q && !misalign && (free_slots >= FW_C);
  // An issued request stays up until acked, even across redirects.
  assign imem_req   = !reset && ((state_q != ST_FETCH) || fetch_ok);
  assign imem_addr  = (state_q == ST_FETCH) ? (pc_q & ALIGN_MASK) : req_addr_q;
  assign ack_take   = imem_req && imem_ack;
  assign id_valid   = count_q != '0;
  assign pop        = id_valid && id_ready && !flush;
  assign start_slot = (FETCH_W > 1) ? 32'(pc_q[2]) : 32'd0;
  assign pc         = pc_q;

  assign id_inst = id_valid ? inst_q[rd_ptr_q] : 32'd0;
  assign id_pc   = id_valid ? qpc_q[rd_ptr_q]  : 32'd0;
  assign id_exc  = id_valid ? exc_q[rd_ptr_q]  : 2'b00;

  always_comb begin
    logic [CNT_W-1:0] push_n;
    logic [PTR_W-1:0] idx;
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    halt_d     = halt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inst_d     = inst_q;
    qpc_d      = qpc_q;
    exc_d      = exc_q;
    push_n     = '0;
    idx        = '0;

    case (state_q)
      ST_FETCH:   if (imem_req && !imem_ack) state_d = ST_WAIT;
      ST_WAIT:    if (imem_ack) state_d = ST_FETCH;
      ST_DISCARD: if (imem_ack) state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase

    if (state_q == ST_FETCH) req_addr_d = imem_addr;

    if (!flush) begin
      if (ack_take && state_q != ST_DISCARD) begin
        // Slots below the fetch PC belong to the block but precede a branch target.
        for (int k = 0; k < FETCH_W; k++) begin
          if (k >= int'(start_slot)) begin
            idx        = wr_ptr_q + PTR_W'(k - int'(start_slot));
            inst_d[idx] = imem_err ? 32'd0 : imem_rdata[32*k +: 32];
            qpc_d[idx]  = imem_addr + 32'(4 * k);
            exc_d[idx]  = {imem_err, 1'b0};
          end
        end
        push_n = CNT_W'(FETCH_W - start_slot);
        pc_d   = imem_addr + BLK_BYTES;
        if (imem_err) halt_d = 1'b1;
      end else if (state_q == ST_FETCH && !halt_q && misalign && free_slots != '0) begin
        inst_d[wr_ptr_q] = 32'd0;
        qpc_d[wr_ptr_q]  = pc_q;
        exc_d[wr_ptr_q]  = 2'b01;
        push_n           = CNT_W'(1);
        halt_d           = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + push_n - CNT_W'(pop);
    end else begin
      // Late data for an abandoned request must still be absorbed.
      state_d  = (imem_req && !imem_ack) ? ST_DISCARD : ST_FETCH;
      pc_d     = flush_pc;
      halt_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inst_q     <= '{default: '0};
      qpc_q      <= '{default: '0};
      exc_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      qpc_q      <= qpc_d;
      exc_q      <= exc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    perf_stall_d = perf_stall_q;
    if (ack_take && state_q != ST_DISCARD && perf_fetch_q != 32'hffff_ffff)
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (flush && perf_flush_q != 32'hffff_ffff)
      perf_flush_d = perf_flush_q + 32'd1;
    if (id_ready && !id_valid && perf_stall_q != 32'hffff_ffff)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end. It replaces the single-slot fetch register with a multi-instruction fetch, a decoupling instruction queue, and a req/ack memory handshake. Sits between the instruction memory/cache port and the ID stage. Accepts exception redirects (highest priority) and branch redirects, and tags each instruction with its PC and fetch-exception code.

Parameters:
FETCH_W, 2, instructions returned per memory access (legal: 1, 2)
IBUF_DEPTH, 4, instruction-queue entries (power of 2, >= 2*FETCH_W)
RESET_PC, 32'hbfc0_0000, fetch PC after reset

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  exception/interrupt redirect request
redirect_pc  input  32  exception redirect target
branch_valid  input  1  resolved branch/jump redirect request
branch_pc  input  32  branch target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, aligned to 4*FETCH_W bytes
imem_ack  input  1  response valid; completes the outstanding request
imem_rdata  input  32*FETCH_W  instruction words; slot k at [32k+31:32k] = addr+4k
imem_err  input  1  bus/address fault qualifying imem_ack
id_valid  output  1  queue head valid
id_ready  input  1  ID accepts head this cycle
id_inst  output  32  head instruction
id_pc  output  32  head PC
id_exc  output  2  head exception {bus_err, misaligned}
pc  output  32  current fetch PC

Behaviour:
- Reset (async, active-high): pc=RESET_PC; queue empty; id_valid=0; id_inst=0; id_pc=0; id_exc=0; imem_req=0; state=FETCH.
- FSM states:
  - FETCH: imem_req=1 when free slots >= FETCH_W and not halted; imem_addr = pc & ~(4*FETCH_W-1). Request held stable until imem_ack. Go WAIT on a cycle with imem_req=1 and no ack.
  - WAIT: hold request; on imem_ack return to FETCH.
  - DISCARD: redirect arrived while a request was outstanding; hold imem_req=1 until imem_ack, drop the data, return to FETCH.
- One outstanding request maximum; imem_ack accepted in the same cycle as the request (zero-wait memory).
- On ack without redirect:
  - Push slots whose PC >= pc, in order. With FETCH_W=2 and pc[2]=1, push only slot 1.
  - Advance pc to imem_addr+4*FETCH_W.
  - If imem_err: pushed entries get inst=0 and id_exc[1]=1, then halt fetching until a redirect.
- Misaligned pc (pc[1:0]!=0) in FETCH: issue no request; push one entry (inst=0, id_pc=pc, id_exc=2'b01); halt until a redirect.
- Pop when id_valid && id_ready. Push and pop in the same cycle are legal; count updates by pushes minus pops. Queue never overflows because of the request gating.
- Redirect priority: redirect_valid > branch_valid.
  - On either: flush queue (this cycle's pop and push are discarded); pc <= target; clear halt.
  - If a request is outstanding and no ack this cycle, go DISCARD. If ack coincides, drop the data and go FETCH.
  - id_valid=0 the cycle after a redirect.
- Pointers wrap modulo IBUF_DEPTH; full when count==IBUF_DEPTH.
- pc arithmetic is 32-bit and wraps silently at 2^32.
- Outputs id_* come from registered queue storage (no combinational path from imem_rdata).

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (acks accepted in WAIT/FETCH), perf_flush_cnt[31:0] (redirects), and perf_stall_cnt[31:0] (cycles with id_ready=1 and id_valid=0). Counters reset to 0 and saturate at 32'hffff_ffff.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, FETCH_W=2, zero-wait memory returning {32'h2, 32'h1}, id_ready=1:
  - imem_addr=32'hbfc0_0000 first.
  - id sequence (pc,inst) = (bfc0_0000,1), (bfc0_0004,2).
  - pc advances to bfc0_0008.
- id_ready=0 for 10 cycles, IBUF_DEPTH=4: at most 4 entries buffered; imem_req drops once free slots < 2; on release, all entries drain in order with no loss or duplication.
- branch_valid with branch_pc=32'h8000_0014 while WAIT:
  - queue flushed; state DISCARD; the late ack data is dropped.
  - Next imem_addr=8000_0010; only the slot with pc 8000_0014 is enqueued.
- redirect_valid and branch_valid in the same cycle (redirect_pc=bfc0_0380, branch_pc=1000_0000): pc=bfc0_0380.
- imem_ack with imem_err=1 at addr 0000_1000: entries carry id_exc=2'b10 and inst=0; no further imem_req until redirect.
- branch_pc=32'h0000_0102: no request issued; single entry with id_exc=2'b01 and id_pc=0000_0102; reset mid-WAIT clears the queue and returns pc=RESET_PC.
